// File: rtl/game_pkg.sv
// game_pkg: shared constants and types for the 2048 board datapath.
//   TILE_W / N   : tile width and board dimension
//   WIN_TILE     : tile value that ends the game and never merges further
//   DIR_*        : one-hot move direction encodings
//   tile_t/board_t, state_t : common types
package game_pkg;

  localparam int unsigned TILE_W   = 12;
  localparam int unsigned N        = 4;
  localparam int unsigned WIN_TILE = 2048;

  localparam logic [3:0] DIR_LEFT  = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  typedef logic [TILE_W-1:0]       tile_t;
  typedef tile_t [N-1:0][N-1:0]    board_t;

  typedef enum logic [1:0] {
    IDLE,
    LANE,
    DONE
  } state_t;

endpackage

// File: rtl/merge_lane.sv
// merge_lane: combinational 2048 merge of one 4-tile lane.
//   lane_in  : tiles e0..e3, e0 at the move edge (may contain gaps)
//   lane_out : compacted, merged, re-compacted lane
//   score    : sum of the doubled values created in this lane
//   merged   : at least one pair merged
//   win      : a merge produced WIN_TILE
module merge_lane #(
  parameter int unsigned TILE_W  = 12,
  parameter int unsigned SCORE_W = 16
) (
  input  logic [3:0][TILE_W-1:0] lane_in,
  output logic [3:0][TILE_W-1:0] lane_out,
  output logic [SCORE_W-1:0]     score,
  output logic                   merged,
  output logic                   win
);
  import game_pkg::*;

  localparam logic [TILE_W-1:0] WIN_T = TILE_W'(WIN_TILE);
  localparam logic [TILE_W:0]   WIN_D = (TILE_W+1)'(WIN_TILE);

  // Move nonzero tiles toward e0, preserving their order.
  function automatic logic [3:0][TILE_W-1:0] compact(input logic [3:0][TILE_W-1:0] v);
    logic [3:0][TILE_W-1:0] r;
    logic [2:0]             k;
    r = '0;
    k = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[i] != '0) begin
        r[k[1:0]] = v[i];
        k = k + 3'd1;
      end
    end
    return r;
  endfunction

  logic [3:0][TILE_W-1:0] work;
  logic [TILE_W:0]        dbl;

  // Zeroing e[n+1] after a merge makes the next iteration's test fail,
  // which both skips to n+2 and stops a fresh tile from merging again.
  always_comb begin
    work   = compact(lane_in);
    dbl    = '0;
    score  = '0;
    merged = 1'b0;
    win    = 1'b0;
    for (int unsigned n = 0; n < 3; n++) begin
      if (work[n] != '0 && work[n] == work[n+1] && work[n] != WIN_T) begin
        dbl       = {1'b0, work[n]} << 1;
        work[n]   = dbl[TILE_W-1:0];
        work[n+1] = '0;
        score     = score + SCORE_W'(dbl);
        merged    = 1'b1;
        if (dbl == WIN_D) win = 1'b1;
      end
    end
    lane_out = compact(work);
  end

endmodule

// File: rtl/tile_merger.sv
// tile_merger: merges equal adjacent tiles of a slid 4x4 board toward the
// move edge, one lane per clock, under a start/done handshake.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : one-cycle request, sampled only in IDLE
//   direction      : one-hot 1000 left, 0100 down, 0010 up, 0001 right
//   matrix         : slid board [row][col], row 0 bottom, col 0 right
//   merged_matrix  : merged and re-compacted board
//   score_delta    : sum of tiles created by merges this move
//   merged / win   : any merge / any merge produced 2048
//   busy / done    : in progress / one-cycle result-valid pulse
module tile_merger #(
  parameter int unsigned TILE_W  = 12,
  parameter int unsigned N       = 4,
  parameter int unsigned SCORE_W = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [3:0]                       direction,
  input  logic [N-1:0][N-1:0][TILE_W-1:0]  matrix,
  output logic [N-1:0][N-1:0][TILE_W-1:0]  merged_matrix,
  output logic [SCORE_W-1:0]               score_delta,
  output logic                             merged,
  output logic                             win,
  output logic                             busy,
  output logic                             done
);
  import game_pkg::*;

  state_t                          state;
  logic [3:0]                      dir_q;
  logic [N-1:0][N-1:0][TILE_W-1:0] work;
  logic [N-1:0][N-1:0][TILE_W-1:0] work_next;
  logic [1:0]                      lane;
  logic [SCORE_W-1:0]              score_acc;
  logic                            merged_acc;
  logic                            win_acc;
  logic                            dir_valid;

  logic [3:0][TILE_W-1:0]          lane_in;
  logic [3:0][TILE_W-1:0]          lane_out;
  logic [SCORE_W-1:0]              lane_score;
  logic                            lane_merged;
  logic                            lane_win;

  assign dir_valid = $onehot(dir_q);

  // Lanes are disjoint, so reading the current lane from the working board
  // (loaded with the captured board) sees exactly the captured tiles.
  always_comb begin
    logic [1:0] ei;
    logic [1:0] er;
    lane_in = '0;
    ei      = '0;
    er      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      ei = 2'(i);
      er = 2'(3 - i);
      case (dir_q)
        DIR_DOWN:  lane_in[i] = work[ei][lane];
        DIR_UP:    lane_in[i] = work[er][lane];
        DIR_LEFT:  lane_in[i] = work[lane][er];
        DIR_RIGHT: lane_in[i] = work[lane][ei];
        default:   lane_in[i] = '0;
      endcase
    end
  end

  merge_lane #(
    .TILE_W  (TILE_W),
    .SCORE_W (SCORE_W)
  ) u_merge_lane (
    .lane_in  (lane_in),
    .lane_out (lane_out),
    .score    (lane_score),
    .merged   (lane_merged),
    .win      (lane_win)
  );

  // An invalid direction writes nothing back, so the board passes through.
  always_comb begin
    logic [1:0] ei;
    logic [1:0] er;
    work_next = work;
    ei        = '0;
    er        = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      ei = 2'(i);
      er = 2'(3 - i);
      case (dir_q)
        DIR_DOWN:  work_next[ei][lane] = lane_out[i];
        DIR_UP:    work_next[er][lane] = lane_out[i];
        DIR_LEFT:  work_next[lane][er] = lane_out[i];
        DIR_RIGHT: work_next[lane][ei] = lane_out[i];
        default:   ;
      endcase
    end
  end

  // done/busy are registered: the DONE state publishes results and raises
  // done, which is visible during the following (IDLE) cycle while busy is
  // still high; IDLE then drops both unless a new start is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dir_q         <= '0;
      work          <= '0;
      lane          <= '0;
      score_acc     <= '0;
      merged_acc    <= 1'b0;
      win_acc       <= 1'b0;
      merged_matrix <= '0;
      score_delta   <= '0;
      merged        <= 1'b0;
      win           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work       <= matrix;
            dir_q      <= direction;
            score_acc  <= '0;
            merged_acc <= 1'b0;
            win_acc    <= 1'b0;
            lane       <= '0;
            busy       <= 1'b1;
            state      <= LANE;
          end else begin
            busy <= 1'b0;
          end
        end
        LANE: begin
          work <= work_next;
          if (dir_valid) begin
            score_acc  <= score_acc + lane_score;
            merged_acc <= merged_acc | lane_merged;
            win_acc    <= win_acc | lane_win;
          end
          lane <= lane + 2'd1;
          if (lane == 2'd3) state <= DONE;
        end
        DONE: begin
          merged_matrix <= work;
          score_delta   <= score_acc;
          merged        <= merged_acc;
          win           <= win_acc;
          done          <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_merger.sv
module tb_tile_merger;

  localparam int TW = 12;
  typedef logic [3:0][3:0][TW-1:0] brd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  direction = 4'b0000;
  brd_t        matrix = '0;
  brd_t        merged_matrix;
  logic [15:0] score_delta;
  logic        merged, win, busy, done;

  int   tests = 0;
  int   fails = 0;
  int   done_count = 0;
  brd_t exp_board = '0;
  int   exp_score = 0;
  bit   exp_merged = 1'b0;
  bit   exp_win = 1'b0;

  always #5 clk = ~clk;

  tile_merger #(.TILE_W(12), .N(4), .SCORE_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .direction     (direction),
    .matrix        (matrix),
    .merged_matrix (merged_matrix),
    .score_delta   (score_delta),
    .merged        (merged),
    .win           (win),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Board position of lane element e of lane k for direction d.
  function automatic void lane_rc(input logic [3:0] d, input int k, input int e,
                                  output int r, output int c);
    r = 0;
    c = 0;
    case (d)
      4'b0100: begin r = e;     c = k;     end
      4'b0010: begin r = 3 - e; c = k;     end
      4'b1000: begin r = k;     c = 3 - e; end
      4'b0001: begin r = k;     c = e;     end
      default: ;
    endcase
  endfunction

  // Reference: gather nonzeros per lane, pair equal neighbours, pad with 0.
  function automatic void model(input brd_t b, input logic [3:0] d, output brd_t o,
                                output int sc, output bit mg, output bit wn);
    int q[$];
    int res[$];
    int r, c, i;
    o = b; sc = 0; mg = 1'b0; wn = 1'b0;
    if ($countones(d) != 1) return;
    for (int k = 0; k < 4; k++) begin
      q.delete();
      res.delete();
      for (int e = 0; e < 4; e++) begin
        lane_rc(d, k, e, r, c);
        if (b[r][c] != 0) q.push_back(int'(b[r][c]));
      end
      i = 0;
      while (i < q.size()) begin
        if (i + 1 < q.size() && q[i] == q[i+1] && q[i] != 2048) begin
          res.push_back(2 * q[i]);
          sc += 2 * q[i];
          mg = 1'b1;
          if (2 * q[i] == 2048) wn = 1'b1;
          i += 2;
        end else begin
          res.push_back(q[i]);
          i++;
        end
      end
      while (res.size() < 4) res.push_back(0);
      for (int e = 0; e < 4; e++) begin
        lane_rc(d, k, e, r, c);
        o[r][c] = TW'(res[e]);
      end
    end
  endfunction

  // Compare process: every done pulse is checked against the model.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      done_count++;
      chk("model board",  merged_matrix, exp_board);
      chk("model score",  score_delta,   exp_score);
      chk("model merged", merged,        exp_merged);
      chk("model win",    win,           exp_win);
    end
  end

  task automatic run_move(input brd_t b, input logic [3:0] d, output int lat, output int bc);
    @(negedge clk);
    matrix = b; direction = d; start = 1'b1;
    model(b, d, exp_board, exp_score, exp_merged, exp_win);
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    bc  = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done && lat < 0) lat = c;
      if (!busy) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    brd_t b;
    brd_t bb;
    logic [3:0][TW-1:0] row;
    int lat, bc, dc0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset busy",  busy, 0);
    chk("reset done",  done, 0);
    chk("reset board", merged_matrix, 0);
    chk("reset score", score_delta, 0);
    chk("reset merged", merged, 0);
    chk("reset win",   win, 0);
    @(negedge clk) rst_n = 1'b1;

    // Down: column 0 = 2,2,2,2
    b = '0;
    for (int r = 0; r < 4; r++) b[r][0] = 2;
    run_move(b, 4'b0100, lat, bc);
    chk("down r0c0", merged_matrix[0][0], 4);
    chk("down r1c0", merged_matrix[1][0], 4);
    chk("down r2c0", merged_matrix[2][0], 0);
    chk("down r3c0", merged_matrix[3][0], 0);
    chk("down score", score_delta, 8);
    chk("down merged", merged, 1);
    chk("down win", win, 0);
    chk("down latency", lat, 5);
    chk("down busy cycles", bc, 6);

    // Left: row 2 cols3..0 = 4,4,8,0; other rows already compacted
    b = '0;
    b[2][3] = 4; b[2][2] = 4; b[2][1] = 8;
    b[0][3] = 2; b[0][2] = 4; b[0][1] = 2; b[0][0] = 4;
    b[3][3] = 16;
    run_move(b, 4'b1000, lat, bc);
    row = '0; row[3] = 8; row[2] = 8;
    chk("left row2", merged_matrix[2], row);
    chk("left row0", merged_matrix[0], b[0]);
    chk("left row3", merged_matrix[3], b[3]);
    chk("left score", score_delta, 8);

    // Right: row 1 cols0..3 = 1024,1024,2048,2048
    b = '0;
    b[1][0] = 1024; b[1][1] = 1024; b[1][2] = 2048; b[1][3] = 2048;
    run_move(b, 4'b0001, lat, bc);
    row = '0; row[0] = 2048; row[1] = 2048; row[2] = 2048;
    chk("right row1", merged_matrix[1], row);
    chk("right score", score_delta, 2048);
    chk("right win", win, 1);

    // Up: column 3 rows3..0 = 2,4,8,16, nothing merges
    b = '0;
    b[3][3] = 2; b[2][3] = 4; b[1][3] = 8; b[0][3] = 16;
    run_move(b, 4'b0010, lat, bc);
    chk("up board", merged_matrix, b);
    chk("up score", score_delta, 0);
    chk("up merged", merged, 0);

    // Invalid directions: mergeable board passes through unchanged
    b = '0;
    for (int r = 0; r < 4; r++) b[r][0] = 2;
    run_move(b, 4'b0000, lat, bc);
    chk("dir0 board", merged_matrix, b);
    chk("dir0 score", score_delta, 0);
    chk("dir0 merged", merged, 0);
    chk("dir0 latency", lat, 5);
    run_move(b, 4'b0110, lat, bc);
    chk("dir0110 board", merged_matrix, b);

    // Down with gaps and a 2048 result
    b = '0;
    b[1][1] = 2; b[3][1] = 2;
    b[0][2] = 2; b[1][2] = 2; b[2][2] = 4;
    b[0][3] = 1024; b[1][3] = 1024;
    run_move(b, 4'b0100, lat, bc);
    chk("gap c1", merged_matrix[0][1], 4);
    chk("gap c1 r1", merged_matrix[1][1], 0);
    chk("gap c2 r0", merged_matrix[0][2], 4);
    chk("gap c2 r1", merged_matrix[1][2], 4);
    chk("gap c3 r0", merged_matrix[0][3], 2048);
    chk("gap score", score_delta, 2056);
    chk("gap win", win, 1);

    // Reset after lane 1 has been processed
    @(negedge clk);
    bb = '0; bb[0][0] = 2; bb[1][0] = 2;
    matrix = bb; direction = 4'b0100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset board", merged_matrix, 0);
    chk("midreset score", score_delta, 0);
    @(negedge clk) rst_n = 1'b1;
    run_move(bb, 4'b0100, lat, bc);
    chk("postreset latency", lat, 5);
    chk("postreset r0c0", merged_matrix[0][0], 4);

    // start pulsed during LANE is ignored
    dc0 = done_count;
    b = '0; b[0][3] = 2; b[0][2] = 2;
    bb = '0; bb[3][0] = 8; bb[3][1] = 8; bb[3][2] = 8;
    @(negedge clk);
    matrix = b; direction = 4'b1000; start = 1'b1;
    model(b, 4'b1000, exp_board, exp_score, exp_merged, exp_win);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    matrix = bb; direction = 4'b0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(negedge clk);
    chk("busy start single done", done_count - dc0, 1);
    chk("busy start score", score_delta, 4);
    chk("busy start r0c3", merged_matrix[0][3], 4);
    run_move(bb, 4'b0001, lat, bc);
    chk("second start done", done_count - dc0, 2);
    chk("second start score", score_delta, 16);
    chk("second start r3c0", merged_matrix[3][0], 16);
    chk("second start r3c1", merged_matrix[3][1], 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
